control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Multi-cycle control unit driving the reduced RISC-V datapath from the control side.
//  Fetches a 32-bit instruction over a req/valid handshake and latches it into an IR.
//  Decodes the IR into register addresses, sign-extended immediate, ALU controls and PC controls.
//  Consumes the datapath EQ flag to resolve branches. Supports ADDI, ADD, BEQ and BNE.
// PARAMETERS
//  DATA_WIDTH        32  immediate/datapath width (>=13)
//  REG_ADDRESS_WIDTH 5   register address width
//  ALU_CTRL_WIDTH    3   ALUctrl width
// PORTS
//  clk        in   1                  clock, all state on rising edge
//  rst        in   1                  synchronous reset, active-high
//  imem_req   out  1                  fetch request to instruction memory
//  imem_valid in   1                  instruction data valid
//  imem_instr in   32                 instruction word
//  EQ         in   1                  ALU equality flag from datapath
//  rs1        out  REG_ADDRESS_WIDTH  IR[19:15]
//  rs2        out  REG_ADDRESS_WIDTH  IR[24:20]
//  rd         out  REG_ADDRESS_WIDTH  IR[11:7]
//  ImmOp      out  DATA_WIDTH         sign-extended immediate
//  ALUsrc     out  1                  1 = ImmOp, 0 = rs2 data
//  ALUctrl    out  ALU_CTRL_WIDTH     0 = ADD, 1 = SUB
//  RegWrite   out  1                  register write enable (single-cycle pulse)
//  pc_en      out  1                  PC update enable (single-cycle pulse)
//  PCsrc      out  1                  1 = PC+ImmOp, 0 = PC+4
//  halted     out  1                  sticky illegal-instruction halt
//  instret    out  32                 retired-instruction count
// BEHAVIOUR
//  - Reset: state=FETCH, IR=0x00000013 (NOP), instret=0, halted=0.
//    imem_req, RegWrite, pc_en and PCsrc are 0 while rst=1.
//    rst overrides any in-flight fetch; imem_valid is ignored in the reset cycle.
//  - FETCH:
//    - imem_req=1.
//    - If imem_valid=1, IR<=imem_instr and go to DECODE; otherwise hold, with req kept high.
//    - imem_valid is ignored whenever imem_req=0.
//  - DECODE: imem_req=0; decode fields are stable from IR; go to EXECUTE. Lasts 1 cycle.
//  - EXECUTE: lasts 1 cycle; pc_en=1; instret+=1 (wraps 2^32-1 -> 0); go to FETCH.
//  - Latency: minimum 3 cycles per instruction (imem_valid in the first FETCH cycle).
//    Each wait cycle adds 1.
//  - rs1, rs2, rd, ImmOp, ALUsrc and ALUctrl are combinational from IR.
//    They are valid in DECODE and EXECUTE.
//  - ADDI (opcode 0010011, funct3 000):
//    ImmOp=sext(IR[31:20]); ALUsrc=1; ALUctrl=ADD; RegWrite=1 in EXECUTE; PCsrc=0.
//  - ADD (opcode 0110011, funct3 000, funct7 0): ALUsrc=0; ALUctrl=ADD; RegWrite=1 in EXECUTE; PCsrc=0.
//  - BEQ/BNE (opcode 1100011, funct3 000/001):
//    ImmOp=sext({IR[31],IR[7],IR[30:25],IR[11:8],1'b0}); ALUsrc=0; ALUctrl=SUB; RegWrite=0.
//    In EXECUTE: PCsrc=EQ for BEQ, PCsrc=~EQ for BNE. EQ is sampled only in EXECUTE.
//  - rd=0: RegWrite is forced to 0; the PC still advances.
//  - PCsrc=0 in every state except a taken-branch EXECUTE.
//  - Any other encoding is illegal; see CONFIGURATION.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//   - An illegal instruction in EXECUTE gives pc_en=0, RegWrite=0 and state<=HALT; instret does not increment.
//   - HALT: halted=1, imem_req=0, all enables 0. Only rst exits HALT.
//  ILLEGAL_TRAP_EN undefined:
//   - An illegal instruction executes as a NOP: pc_en=1, PCsrc=0, RegWrite=0, instret+=1.
//   - There is no HALT state; halted is tied to 0.
// TESTING
//  - addi x10,x0,5 (0x00500513), valid in FETCH cycle 1:
//    DECODE gives rs1=0, rd=10, ImmOp=5, ALUsrc=1.
//    EXECUTE gives RegWrite=1, pc_en=1, PCsrc=0; instret=1.
//  - add x11,x10,x10 (0x00A505B3): rs1=rs2=10, rd=11, ALUsrc=0, ALUctrl=0; RegWrite=1 in EXECUTE.
//  - bne x10,x0,-4 (0xFE051EE3): ImmOp=0xFFFFFFFC, ALUctrl=1.
//    With EQ=0 in EXECUTE: PCsrc=1. With EQ=1: PCsrc=0. RegWrite=0 in both cases.
//  - imem_valid held low 3 cycles: imem_req stays 1 for 4 cycles, no pc_en meanwhile.
//    addi x0,x0,5 (0x00500013) then gives RegWrite=0, pc_en=1.
//  - Illegal 0x00000000:
//    With ILLEGAL_TRAP_EN: halted=1 from the cycle after EXECUTE, imem_req=0 forever, instret unchanged.
//    Without ILLEGAL_TRAP_EN: pc_en=1, instret+1.
//  - rst asserted in DECODE: next cycle state=FETCH, all enables 0, instret=0.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute control unit for a reduced RV32I datapath.
// Optional macro ILLEGAL_TRAP_EN: illegal encodings halt the core instead of retiring as NOPs.
module control_sequencer #(
    parameter int DATA_WIDTH        = 32,
    parameter int REG_ADDRESS_WIDTH = 5,
    parameter int ALU_CTRL_WIDTH    = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         imem_req,
    input  logic                         imem_valid,
    input  logic [31:0]                  imem_instr,
    input  logic                         EQ,
    output logic [REG_ADDRESS_WIDTH-1:0] rs1,
    output logic [REG_ADDRESS_WIDTH-1:0] rs2,
    output logic [REG_ADDRESS_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]        ImmOp,
    output logic                         ALUsrc,
    output logic [ALU_CTRL_WIDTH-1:0]    ALUctrl,
    output logic                         RegWrite,
    output logic                         pc_en,
    output logic                         PCsrc,
    output logic                         halted,
    output logic [31:0]                  instret
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_DECODE,
`ifdef ILLEGAL_TRAP_EN
        S_EXECUTE,
        S_HALT
`else
        S_EXECUTE
`endif
    } state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_ir;
    logic [31:0] r_instret;
    logic        w_ir_load;
    logic        w_retire;

    logic [6:0]         w_opcode;
    logic [2:0]         w_funct3;
    logic [6:0]         w_funct7;
    logic               w_is_addi;
    logic               w_is_add;
    logic               w_is_br;
    logic               w_is_bne;
    logic               w_legal;
    logic               w_rd_nz;
    logic signed [11:0] w_iimm;
    logic signed [12:0] w_bimm;

    assign w_opcode = r_ir[6:0];
    assign w_funct3 = r_ir[14:12];
    assign w_funct7 = r_ir[31:25];

    assign w_is_addi = (w_opcode == 7'b0010011) && (w_funct3 == 3'b000);
    assign w_is_add  = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000)
                    && (w_funct7 == 7'b0000000);
    assign w_is_br   = (w_opcode == 7'b1100011) && (w_funct3[2:1] == 2'b00);
    assign w_is_bne  = w_is_br && w_funct3[0];
    assign w_legal   = w_is_addi || w_is_add || w_is_br;
    assign w_rd_nz   = (r_ir[11:7] != 5'd0);

    assign w_iimm = r_ir[31:20];
    assign w_bimm = {r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};

    assign rs1     = REG_ADDRESS_WIDTH'(r_ir[19:15]);
    assign rs2     = REG_ADDRESS_WIDTH'(r_ir[24:20]);
    assign rd      = REG_ADDRESS_WIDTH'(r_ir[11:7]);
    assign ImmOp   = w_is_br ? DATA_WIDTH'(w_bimm) : DATA_WIDTH'(w_iimm);
    assign ALUsrc  = w_is_addi;
    assign ALUctrl = w_is_br ? ALU_CTRL_WIDTH'(1) : ALU_CTRL_WIDTH'(0);
    assign instret = r_instret;

`ifdef ILLEGAL_TRAP_EN
    assign halted = (r_state == S_HALT) && !rst;
`else
    assign halted = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_ir      <= NOP;
            r_instret <= 32'd0;
        end else begin
            r_state <= w_state_next;
            if (w_ir_load) r_ir <= imem_instr;
            if (w_retire) r_instret <= r_instret + 32'd1;
        end
    end

    // Strobes are gated by rst so nothing leaks out while reset is held.
    always_comb begin
        w_state_next = r_state;
        w_ir_load    = 1'b0;
        w_retire     = 1'b0;
        imem_req     = 1'b0;
        pc_en        = 1'b0;
        RegWrite     = 1'b0;
        PCsrc        = 1'b0;
        if (!rst) begin
            unique case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_valid) begin
                        w_ir_load    = 1'b1;
                        w_state_next = S_DECODE;
                    end
                end
                S_DECODE: begin
                    w_state_next = S_EXECUTE;
                end
                S_EXECUTE: begin
                    w_state_next = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
                    if (!w_legal) begin
                        w_state_next = S_HALT;
                    end else
`endif
                    begin
                        pc_en    = 1'b1;
                        w_retire = 1'b1;
                        RegWrite = w_legal && !w_is_br && w_rd_nz;
                        PCsrc    = w_is_br && (EQ ^ w_is_bne);
                    end
                end
`ifdef ILLEGAL_TRAP_EN
                S_HALT: begin
                    w_state_next = S_HALT;
                end
`endif
                default: begin
                    w_state_next = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected decode/execute results
// are queued per instruction and popped when its DECODE/EXECUTE cycles are seen.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_instr = 32'd0;
    logic        EQ = 1'b0;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] ImmOp;
    logic        ALUsrc;
    logic [2:0]  ALUctrl;
    logic        RegWrite, pc_en, PCsrc, halted;
    logic [31:0] instret;

    control_sequencer dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_valid(imem_valid),
        .imem_instr(imem_instr), .EQ(EQ),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .ImmOp(ImmOp), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl),
        .RegWrite(RegWrite), .pc_en(pc_en), .PCsrc(PCsrc),
        .halted(halted), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        alusrc;
        logic [2:0]  aluctrl;
        logic        regwrite;
        logic        pc_en;
        logic        pcsrc;
        logic [31:0] instret;
    } rec_t;

    rec_t        exp_q[$];
    rec_t        e;
    rec_t        obs_dec, obs_exe;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model_instret = 32'd0;
    int          obs_req_cycles;
    logic        obs_fetch_pc_en;
    logic        obs_dec_req;
    logic        obs_post_halted;
    logic        obs_post_req;
    logic [31:0] obs_post_instret;

    task automatic sample(output rec_t r);
        r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
        r.imm = ImmOp; r.alusrc = ALUsrc; r.aluctrl = ALUctrl;
        r.regwrite = RegWrite; r.pc_en = pc_en; r.pcsrc = PCsrc;
        r.instret = instret;
    endtask

    // One instruction: waits idle FETCH cycles, then valid, DECODE, EXECUTE.
    task automatic drive(input logic [31:0] instr, input int waits,
                         input logic eq);
        obs_req_cycles  = 0;
        obs_fetch_pc_en = 1'b0;
        for (int i = 0; i < waits; i++) begin
            @(negedge clk);
            imem_valid = 1'b0;
            imem_instr = $urandom;
            #1;
            if (imem_req) obs_req_cycles++;
            if (pc_en) obs_fetch_pc_en = 1'b1;
        end
        @(negedge clk);
        imem_valid = 1'b1;
        imem_instr = instr;
        #1;
        if (imem_req) obs_req_cycles++;
        if (pc_en) obs_fetch_pc_en = 1'b1;
        @(negedge clk);
        imem_valid = 1'b1;
        imem_instr = $urandom;
        EQ = ~eq;
        #1;
        obs_dec_req = imem_req;
        sample(obs_dec);
        @(negedge clk);
        imem_valid = 1'b0;
        EQ = eq;
        #1;
        sample(obs_exe);
        @(posedge clk);
        #1;
        obs_post_halted  = halted;
        obs_post_req     = imem_req;
        obs_post_instret = instret;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        imem_valid = 1'b1;
        imem_instr = 32'h00A505B3;
        EQ = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if ({imem_req, pc_en, RegWrite, PCsrc, halted} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_strobes got %b exp 00000",
                     {imem_req, pc_en, RegWrite, PCsrc, halted});
        end
        @(negedge clk);
        rst = 1'b0;
        imem_valid = 1'b0;
        #1;
        model_instret = 32'd0;
        n_checks++;
        if (imem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_fetch_req got %b exp 1", imem_req);
        end
        n_checks++;
        if (instret !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_instret got %0d exp 0", instret);
        end
        n_checks++;
        if ({rd, rs1, ImmOp, ALUsrc} !== {5'd0, 5'd0, 32'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL rst_ir_nop rd=%0d rs1=%0d imm=%h src=%b exp 0 0 0 1",
                     rd, rs1, ImmOp, ALUsrc);
        end
    endtask

    task automatic test_addi();
        exp_q.push_back('{rs1:5'd0, rs2:5'd5, rd:5'd10, imm:32'd5,
                          alusrc:1'b1, aluctrl:3'd0, regwrite:1'b1,
                          pc_en:1'b1, pcsrc:1'b0,
                          instret:model_instret + 32'd1});
        drive(32'h00500513, 0, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if ({obs_dec.rs1, obs_dec.rd} !== {e.rs1, e.rd}) begin
            n_fail++;
            $display("FAIL addi_regs rs1=%0d rd=%0d exp %0d %0d",
                     obs_dec.rs1, obs_dec.rd, e.rs1, e.rd);
        end
        n_checks++;
        if ({obs_dec.imm, obs_dec.alusrc, obs_dec.aluctrl}
            !== {e.imm, e.alusrc, e.aluctrl}) begin
            n_fail++;
            $display("FAIL addi_imm imm=%h src=%b ctl=%0d exp %h %b %0d",
                     obs_dec.imm, obs_dec.alusrc, obs_dec.aluctrl,
                     e.imm, e.alusrc, e.aluctrl);
        end
        n_checks++;
        if ({obs_dec_req, obs_dec.regwrite, obs_dec.pc_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL addi_dec_strobes got %b exp 000",
                     {obs_dec_req, obs_dec.regwrite, obs_dec.pc_en});
        end
        n_checks++;
        if ({obs_exe.regwrite, obs_exe.pc_en, obs_exe.pcsrc}
            !== {e.regwrite, e.pc_en, e.pcsrc}) begin
            n_fail++;
            $display("FAIL addi_exe got %b exp %b",
                     {obs_exe.regwrite, obs_exe.pc_en, obs_exe.pcsrc},
                     {e.regwrite, e.pc_en, e.pcsrc});
        end
        n_checks++;
        if (obs_post_instret !== e.instret || obs_req_cycles != 1) begin
            n_fail++;
            $display("FAIL addi_retire instret=%0d req=%0d exp %0d 1",
                     obs_post_instret, obs_req_cycles, e.instret);
        end
        model_instret = e.instret;
    endtask

    task automatic test_add();
        exp_q.push_back('{rs1:5'd10, rs2:5'd10, rd:5'd11, imm:32'd0,
                          alusrc:1'b0, aluctrl:3'd0, regwrite:1'b1,
                          pc_en:1'b1, pcsrc:1'b0,
                          instret:model_instret + 32'd1});
        drive(32'h00A505B3, 0, 1'b1);
        e = exp_q.pop_front();
        n_checks++;
        if ({obs_dec.rs1, obs_dec.rs2, obs_dec.rd}
            !== {e.rs1, e.rs2, e.rd}) begin
            n_fail++;
            $display("FAIL add_regs got %0d %0d %0d exp %0d %0d %0d",
                     obs_dec.rs1, obs_dec.rs2, obs_dec.rd,
                     e.rs1, e.rs2, e.rd);
        end
        n_checks++;
        if ({obs_dec.alusrc, obs_dec.aluctrl} !== {e.alusrc, e.aluctrl}) begin
            n_fail++;
            $display("FAIL add_alu src=%b ctl=%0d exp %b %0d",
                     obs_dec.alusrc, obs_dec.aluctrl, e.alusrc, e.aluctrl);
        end
        n_checks++;
        if ({obs_exe.regwrite, obs_exe.pc_en, obs_exe.pcsrc}
            !== {e.regwrite, e.pc_en, e.pcsrc}) begin
            n_fail++;
            $display("FAIL add_exe got %b exp %b",
                     {obs_exe.regwrite, obs_exe.pc_en, obs_exe.pcsrc},
                     {e.regwrite, e.pc_en, e.pcsrc});
        end
        n_checks++;
        if (obs_post_instret !== e.instret) begin
            n_fail++;
            $display("FAIL add_instret got %0d exp %0d",
                     obs_post_instret, e.instret);
        end
        model_instret = e.instret;
    endtask

    task automatic test_branch(input logic [31:0] instr, input logic eq,
                               input logic taken);
        exp_q.push_back('{rs1:5'd10, rs2:5'd0, rd:5'd29, imm:32'hFFFFFFFC,
                          alusrc:1'b0, aluctrl:3'd1, regwrite:1'b0,
                          pc_en:1'b1, pcsrc:taken,
                          instret:model_instret + 32'd1});
        drive(instr, 1, eq);
        e = exp_q.pop_front();
        n_checks++;
        if ({obs_dec.imm, obs_dec.aluctrl, obs_dec.alusrc, obs_dec.rs1}
            !== {e.imm, e.aluctrl, e.alusrc, e.rs1}) begin
            n_fail++;
            $display("FAIL br_dec %h imm=%h ctl=%0d src=%b rs1=%0d exp %h %0d %b %0d",
                     instr, obs_dec.imm, obs_dec.aluctrl, obs_dec.alusrc,
                     obs_dec.rs1, e.imm, e.aluctrl, e.alusrc, e.rs1);
        end
        n_checks++;
        if (obs_dec.pcsrc !== 1'b0) begin
            n_fail++;
            $display("FAIL br_dec_pcsrc %h got %b exp 0", instr, obs_dec.pcsrc);
        end
        n_checks++;
        if ({obs_exe.regwrite, obs_exe.pc_en, obs_exe.pcsrc}
            !== {e.regwrite, e.pc_en, e.pcsrc}) begin
            n_fail++;
            $display("FAIL br_exe %h eq=%b got %b exp %b", instr, eq,
                     {obs_exe.regwrite, obs_exe.pc_en, obs_exe.pcsrc},
                     {e.regwrite, e.pc_en, e.pcsrc});
        end
        n_checks++;
        if (obs_post_instret !== e.instret) begin
            n_fail++;
            $display("FAIL br_instret got %0d exp %0d",
                     obs_post_instret, e.instret);
        end
        model_instret = e.instret;
    endtask

    task automatic test_wait_x0();
        exp_q.push_back('{rs1:5'd0, rs2:5'd5, rd:5'd0, imm:32'd5,
                          alusrc:1'b1, aluctrl:3'd0, regwrite:1'b0,
                          pc_en:1'b1, pcsrc:1'b0,
                          instret:model_instret + 32'd1});
        drive(32'h00500013, 3, 1'b0);
        e = exp_q.pop_front();
        n_checks++;
        if (obs_req_cycles != 4 || obs_fetch_pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_fetch req_cycles=%0d pc_en=%b exp 4 0",
                     obs_req_cycles, obs_fetch_pc_en);
        end
        n_checks++;
        if ({obs_exe.regwrite, obs_exe.pc_en} !== {e.regwrite, e.pc_en}) begin
            n_fail++;
            $display("FAIL wait_x0_exe got %b exp %b",
                     {obs_exe.regwrite, obs_exe.pc_en},
                     {e.regwrite, e.pc_en});
        end
        n_checks++;
        if (obs_post_instret !== e.instret) begin
            n_fail++;
            $display("FAIL wait_instret got %0d exp %0d",
                     obs_post_instret, e.instret);
        end
        model_instret = e.instret;
    endtask

    task automatic test_back_to_back();
        int w;
        for (int k = 1; k <= 6; k++) begin
            exp_q.push_back('{rs1:5'd0, rs2:5'(k), rd:5'(k + 3),
                              imm:32'(k), alusrc:1'b1, aluctrl:3'd0,
                              regwrite:1'b1, pc_en:1'b1, pcsrc:1'b0,
                              instret:model_instret + 32'd1});
            w = $urandom_range(0, 2);
            drive({12'(k), 5'd0, 3'b000, 5'(k + 3), 7'b0010011}, w, 1'b1);
            e = exp_q.pop_front();
            n_checks++;
            if ({obs_dec.rd, obs_dec.imm, obs_exe.regwrite, obs_post_instret}
                !== {e.rd, e.imm, e.regwrite, e.instret}) begin
                n_fail++;
                $display("FAIL b2b_%0d rd=%0d imm=%h we=%b ir=%0d exp %0d %h %b %0d",
                         k, obs_dec.rd, obs_dec.imm, obs_exe.regwrite,
                         obs_post_instret, e.rd, e.imm, e.regwrite, e.instret);
            end
            n_checks++;
            if (obs_req_cycles != w + 1) begin
                n_fail++;
                $display("FAIL b2b_req_%0d got %0d exp %0d",
                         k, obs_req_cycles, w + 1);
            end
            model_instret = e.instret;
        end
    endtask

    task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
        drive(32'h00000000, 0, 1'b0);
        n_checks++;
        if ({obs_exe.pc_en, obs_exe.regwrite} !== 2'b00) begin
            n_fail++;
            $display("FAIL trap_exe got %b exp 00",
                     {obs_exe.pc_en, obs_exe.regwrite});
        end
        n_checks++;
        if ({obs_post_halted, obs_post_req} !== 2'b10
            || obs_post_instret !== model_instret) begin
            n_fail++;
            $display("FAIL trap_halt halted=%b req=%b instret=%0d exp 1 0 %0d",
                     obs_post_halted, obs_post_req, obs_post_instret,
                     model_instret);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            imem_valid = 1'b1;
            imem_instr = 32'h00500513;
            #1;
            n_checks++;
            if ({halted, imem_req, pc_en, RegWrite} !== 4'b1000
                || instret !== model_instret) begin
                n_fail++;
                $display("FAIL trap_hold_%0d got %b instret=%0d exp 1000 %0d",
                         i, {halted, imem_req, pc_en, RegWrite}, instret,
                         model_instret);
            end
        end
        imem_valid = 1'b0;
`else
        logic [31:0] ill [2];
        ill[0] = 32'h40A505B3;
        ill[1] = 32'h00000000;
        for (int i = 0; i < 2; i++) begin
            drive(ill[i], 0, 1'b1);
            n_checks++;
            if ({obs_exe.pc_en, obs_exe.pcsrc, obs_exe.regwrite} !== 3'b100) begin
                n_fail++;
                $display("FAIL nop_exe %h got %b exp 100", ill[i],
                         {obs_exe.pc_en, obs_exe.pcsrc, obs_exe.regwrite});
            end
            n_checks++;
            if (obs_post_instret !== model_instret + 32'd1
                || obs_post_halted !== 1'b0) begin
                n_fail++;
                $display("FAIL nop_retire %h instret=%0d halted=%b exp %0d 0",
                         ill[i], obs_post_instret, obs_post_halted,
                         model_instret + 32'd1);
            end
            model_instret = model_instret + 32'd1;
        end
`endif
    endtask

    task automatic test_reset_in_decode();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        model_instret = 32'd0;
        n_checks++;
        if ({halted, imem_req} !== 2'b01 || instret !== 32'd0) begin
            n_fail++;
            $display("FAIL rst_exit halted=%b req=%b instret=%0d exp 0 1 0",
                     halted, imem_req, instret);
        end
        drive(32'h00500513, 0, 1'b0);
        n_checks++;
        if (obs_post_instret !== 32'd1) begin
            n_fail++;
            $display("FAIL rstd_pre got %0d exp 1", obs_post_instret);
        end
        @(negedge clk);
        imem_valid = 1'b1;
        imem_instr = 32'h00A505B3;
        @(negedge clk);
        imem_valid = 1'b0;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({imem_req, pc_en, RegWrite, PCsrc} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rstd_strobes got %b exp 0000",
                     {imem_req, pc_en, RegWrite, PCsrc});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({imem_req, pc_en, RegWrite, PCsrc} !== 4'b1000
            || instret !== 32'd0 || rd !== 5'd0) begin
            n_fail++;
            $display("FAIL rstd_fetch got %b instret=%0d rd=%0d exp 1000 0 0",
                     {imem_req, pc_en, RegWrite, PCsrc}, instret, rd);
        end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_add();
        test_branch(32'hFE051EE3, 1'b0, 1'b1);
        test_branch(32'hFE051EE3, 1'b1, 1'b0);
        test_branch(32'hFE050EE3, 1'b1, 1'b1);
        test_branch(32'hFE050EE3, 1'b0, 1'b0);
        test_wait_x0();
        test_back_to_back();
        test_illegal();
        test_reset_in_decode();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
